// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiplier and restoring divider, one bit per cycle.
// Optional macro MDU_EARLY_OUT_EN shortcuts divide-by-zero, signed overflow and multiply-by-zero to one BUSY cycle.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func_3,
    input  logic [XLEN-1:0] op_1,
    input  logic [XLEN-1:0] op_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]      r_func;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opb;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_main;
    logic            r_neg_rem;
    logic            r_early;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_sgn_a;
    logic            w_sgn_b;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_b_zero;
    logic            w_div0;
    logic            w_early;
    logic [XLEN-1:0] w_hi_ld;
    logic [XLEN-1:0] w_lo_ld;
    logic [XLEN-1:0] w_opb_ld;

    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_dshift;
    logic [XLEN+1:0]   w_ddiff;
    logic              w_dneg;
    logic [XLEN-1:0]   w_hi_it;
    logic [XLEN-1:0]   w_lo_it;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_res;

    assign w_accept = in_valid & (r_state == S_IDLE);

    // Operand signedness per opcode
    always_comb begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (func_3)
            F_MULH, F_DIV, F_REM: begin
                w_sgn_a = 1'b1;
                w_sgn_b = 1'b1;
            end
            F_MULHSU: begin
                w_sgn_a = 1'b1;
                w_sgn_b = 1'b0;
            end
            default: begin
                w_sgn_a = 1'b0;
                w_sgn_b = 1'b0;
            end
        endcase
    end

    assign w_a_neg  = w_sgn_a & op_1[XLEN-1];
    assign w_b_neg  = w_sgn_b & op_2[XLEN-1];
    assign w_a_mag  = w_a_neg ? -op_1 : op_1;
    assign w_b_mag  = w_b_neg ? -op_2 : op_2;
    assign w_b_zero = (op_2 == {XLEN{1'b0}});
    assign w_div0   = func_3[2] & w_b_zero;

`ifdef MDU_EARLY_OUT_EN
    assign w_early = w_div0
                   | (w_sgn_b & func_3[2] & (op_1 == {1'b1, {(XLEN-1){1'b0}}}) & (op_2 == {XLEN{1'b1}}))
                   | (~func_3[2] & ((op_1 == {XLEN{1'b0}}) | w_b_zero));
`else
    assign w_early = 1'b0;
`endif

    // Datapath load values; early-out operations are loaded with their final magnitudes
    always_comb begin
        w_hi_ld  = {XLEN{1'b0}};
        w_lo_ld  = {XLEN{1'b0}};
        w_opb_ld = {XLEN{1'b0}};
        if (func_3[2]) begin
            w_lo_ld  = w_a_mag;
            w_opb_ld = w_b_mag;
        end else begin
            w_lo_ld  = w_b_mag;
            w_opb_ld = w_a_mag;
        end
        if (w_early && w_div0) begin
            w_hi_ld = w_a_mag;
            w_lo_ld = {XLEN{1'b1}};
        end else if (w_early && !func_3[2]) begin
            w_lo_ld = {XLEN{1'b0}};
        end else begin
            w_hi_ld = {XLEN{1'b0}};
        end
    end

    // One iteration step: hi:lo is accumulator:multiplier or remainder:dividend/quotient
    always_comb begin
        w_msum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opb : {XLEN{1'b0}})};
        w_dshift = {r_hi, r_lo[XLEN-1]};
        w_ddiff  = {1'b0, w_dshift} - {2'b00, r_opb};
        w_dneg   = w_ddiff[XLEN+1] | w_ddiff[XLEN];
        if (r_func[2]) begin
            w_hi_it = w_dneg ? w_dshift[XLEN-1:0] : w_ddiff[XLEN-1:0];
            w_lo_it = {r_lo[XLEN-2:0], ~w_dneg};
        end else begin
            w_hi_it = w_msum[XLEN:1];
            w_lo_it = {w_msum[0], r_lo[XLEN-1:1]};
        end
    end

    // Sign correction and result selection
    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_s = r_neg_main ? -w_prod : w_prod;
        w_quo_s  = r_neg_main ? -r_lo : r_lo;
        w_rem_s  = r_neg_rem ? -r_hi : r_hi;
        case (r_func)
            F_MUL:                    w_res = w_prod_s[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: w_res = w_prod_s[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:            w_res = w_quo_s;
            F_REM, F_REMU:            w_res = w_rem_s;
            default:                  w_res = {XLEN{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; DONE releases only after the result has been presented
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_state_nxt = S_BUSY;
                else          w_state_nxt = S_IDLE;
            end
            S_BUSY: begin
                if (r_early || (r_cnt == LAST)) w_state_nxt = S_DONE;
                else                           w_state_nxt = S_BUSY;
            end
            S_DONE: begin
                if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
                else                          w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_IDLE:  begin in_ready = 1'b1; busy = 1'b0; end
            S_BUSY:  begin in_ready = 1'b0; busy = 1'b1; end
            S_DONE:  begin in_ready = 1'b0; busy = 1'b1; end
            default: begin in_ready = 1'b0; busy = 1'b0; end
        endcase
    end

    // Datapath registers, iteration counter and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_func      <= 3'b000;
            r_hi        <= {XLEN{1'b0}};
            r_lo        <= {XLEN{1'b0}};
            r_opb       <= {XLEN{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_neg_main  <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_early     <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_func     <= func_3;
                        r_hi       <= w_hi_ld;
                        r_lo       <= w_lo_ld;
                        r_opb      <= w_opb_ld;
                        r_cnt      <= {CW{1'b0}};
                        r_neg_main <= (w_a_neg ^ w_b_neg) & ~w_div0;
                        r_neg_rem  <= w_a_neg;
                        r_early    <= w_early;
                    end
                end
                S_BUSY: begin
                    if (!r_early) begin
                        r_hi  <= w_hi_it;
                        r_lo  <= w_lo_it;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_result    <= w_res;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed + random bench for mdu_iter (XLEN=32) with a result/latency scoreboard.
module tb_mdu_iter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      func_3;
    logic [XLEN-1:0] op_1;
    logic [XLEN-1:0] op_2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];
    int          lat_q[$];

    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .func_3   (func_3),
        .op_1     (op_1),
        .op_2     (op_2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit early_en;
        bit cond;
`ifdef MDU_EARLY_OUT_EN
        early_en = 1'b1;
`else
        early_en = 1'b0;
`endif
        cond = (f[2] && b == 32'd0)
             || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
             || (!f[2] && (a == 32'd0 || b == 32'd0));
        return (early_en && cond) ? 2 : XLEN + 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int          cyc;
        bit          got;
        bit          ir_bad;
        bit          bz_bad;
        logic [31:0] e;
        int          el;
        @(negedge clk);
        check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        func_3   = f;
        op_1     = a;
        op_2     = b;
        in_valid = 1'b1;
        sb_q.push_back(exp);
        lat_q.push_back(lat_of(f, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_1     = $urandom;
        op_2     = $urandom;
        func_3   = 3'($urandom);
        cyc = 0; got = 1'b0; ir_bad = 1'b0; bz_bad = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
            end else begin
                if (in_ready) ir_bad = 1'b1;
                if (!busy)    bz_bad = 1'b1;
            end
        end
        e  = sb_q.pop_front();
        el = lat_q.pop_front();
        check({tag, " out_valid seen"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(el));
        check({tag, " in_ready low/busy high while busy"}, {62'd0, ir_bad, bz_bad}, 64'd0);
        check({tag, " result"}, 64'(result), 64'(e));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " hold valid/ready/result"}, {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, e});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " after release"}, {29'd0, out_valid, in_ready, busy, result}, {29'd0, 1'b0, 1'b1, 1'b0, e});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ov_seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        func_3    = 3'd0;
        op_1      = 32'd0;
        op_2      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);

        run_op("MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("MULH min*min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op("MULHU max*max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("MULHSU -1*max",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        run_op("REM -7/2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        run_op("DIVU 100/7",      3'd5, 32'd100,        32'd7,         32'd14,        0);
        run_op("REMU 100/7",      3'd7, 32'd100,        32'd7,         32'd2,         0);
        run_op("DIVU 5/0",        3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op("REMU 5/0",        3'd7, 32'd5,          32'd0,         32'd5,         0);
        run_op("DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
        run_op("DIV -7/0",        3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 0);
        run_op("REM -7/0",        3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 0);
        run_op("DIV 7/-2",        3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        run_op("REM 7/-2",        3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         0);
        run_op("MUL 0*x",         3'd0, 32'd0,          32'h0001_2345, 32'd0,         0);
        run_op("MULH hold",       3'd1, 32'hFFFF_FFFF,  32'd5,         32'hFFFF_FFFF, 10);

        for (int i = 0; i < 6; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom_range(1, 1000);
            run_op("random", rf, ra, rb, ref_mdu(rf, ra, rb), 0);
        end

        // Reset in the middle of a multiply; the abandoned operation must never complete
        @(negedge clk);
        func_3   = 3'd0;
        op_1     = 32'd123;
        op_2     = 32'd456;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("midreset in_ready", 64'(in_ready), 64'd1);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset result", 64'(result), 64'd0);
        ov_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        check("midreset no stale out_valid", 64'(ov_seen), 64'd0);
        run_op("after reset DIVU", 3'd5, 32'd1000, 32'd33, 32'd30, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
